key_filter: RTL and testbench
=============================

// Module: key_filter
// PURPOSE
//  Input-side counterpart of the LED blinker: reads one raw push-button instead of driving an LED.
//  Synchronises key_in to sys_clk and debounces it with a counter-qualified FSM.
//  Emits one-cycle press, release and long-press event pulses, a debounced level and a press count.
//  Sits between a board key pin and user logic (mode select, counter control, LED logic).
// PARAMETERS
//  KEY_ACTIVE_LOW  1           1: key_in low = pressed; 0: key_in high = pressed
//  CNT_W           20          debounce counter width
//  CNT_MAX         999_999     debounce compare value; 20 ms at 50 MHz; must fit CNT_W, >= 1
//  LONG_W          25          hold counter width
//  LONG_MAX        24_999_999  long-press compare value; 0.5 s at 50 MHz; must fit LONG_W, >= 1
// PORTS
//  sys_clk       in   1  system clock, 50 MHz
//  sys_rst_n     in   1  reset, asynchronous, active-low
//  key_in        in   1  raw asynchronous button pin, bouncing
//  key_state     out  1  debounced level; 1 = pressed
//  key_flag      out  1  one-cycle pulse on qualified press
//  key_rel_flag  out  1  one-cycle pulse on qualified release
//  long_flag     out  1  one-cycle pulse, at most once per press, when hold time reached
//  press_cnt     out  8  number of qualified presses, modulo 256
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - State IDLE; both counters 0.
//   - All outputs 0.
//   - Synchroniser flops load the released pin level (1 if KEY_ACTIVE_LOW, else 0).
//  Synchroniser and normalisation
//   - Two-flop synchroniser on key_in gives s2.
//   - pressed = KEY_ACTIVE_LOW ? ~s2 : s2.
//   - FSM uses only pressed.
//  FSM states: IDLE, P_FILT, DOWN, R_FILT; cnt = debounce counter, hold = hold counter.
//   - IDLE: pressed -> P_FILT, cnt<=0.
//   - P_FILT, !pressed: -> IDLE, cnt<=0 (bounce rejected, no flag).
//   - P_FILT, pressed, cnt==CNT_MAX: -> DOWN; key_flag<=1; key_state<=1; press_cnt<=press_cnt+1; hold<=0.
//   - P_FILT, pressed, cnt<CNT_MAX: cnt<=cnt+1.
//   - DOWN, pressed, hold<LONG_MAX: hold<=hold+1.
//   - DOWN, pressed, hold==LONG_MAX: long_flag<=1 for exactly one cycle.
//       hold then saturates at LONG_MAX+1; no further long_flag this press.
//       Size LONG_W so LONG_MAX+1 fits, or add a sticky done bit.
//   - DOWN, !pressed: -> R_FILT, cnt<=0; hold frozen.
//   - R_FILT, pressed: -> DOWN, cnt<=0 (release bounce); hold resumes from frozen value.
//   - R_FILT, !pressed, cnt==CNT_MAX: -> IDLE; key_rel_flag<=1; key_state<=0; hold<=0.
//   - R_FILT, !pressed, cnt<CNT_MAX: cnt<=cnt+1.
//  Timing and flags
//   - All outputs are registered; flags are high for exactly one sys_clk cycle.
//   - Latency: let edge 0 be the first edge that samples key_in pressed, with the pin held stable.
//       key_flag is high in the cycle after edge CNT_MAX+3.
//       Release is symmetric for key_rel_flag.
//   - long_flag goes high LONG_MAX+1 cycles after key_flag (no release glitches in between).
//   - key_flag, long_flag and key_rel_flag are mutually exclusive in any cycle.
//   - press_cnt wraps 255 -> 0 with no indication.
//   - A glitch shorter than CNT_MAX+1 stable cycles produces no flag and no key_state change.
//   - A new press is accepted only after a qualified release (IDLE reached).
//   - Reset asserted mid-press (any state): immediate return to reset values, no flags emitted.
//       After release, a still-held key is treated as a new press and must be re-qualified.
// TESTING (bench uses CNT_MAX=9, LONG_MAX=49, KEY_ACTIVE_LOW=1)
//  - Clean press: key_in 1->0 sampled at edge 0, then held low.
//      -> key_flag pulse after edge 12; key_state=1; press_cnt=1.
//  - Press bounce: key_in low 5 cycles, high 3, then low held.
//      -> no early flag; single key_flag 13 cycles after final low; press_cnt=1.
//  - Long press: hold low 100 cycles past key_flag.
//      -> exactly one long_flag, 50 cycles after key_flag; then release.
//      -> key_rel_flag 13 cycles after key_in high; key_state=0.
//  - Short press: low for 30 cycles total (under long time).
//      -> key_flag and key_rel_flag each once; long_flag never.
//  - Wrap: 256 clean press/release cycles -> press_cnt returns to 0.
//      -> 256 key_flag and 256 key_rel_flag pulses.
//  - Reset mid-DOWN: assert sys_rst_n=0 for 3 cycles, key held low.
//      -> outputs 0 immediately; after release a fresh key_flag 13 cycles later; press_cnt=1.

Source files
------------

// File: rtl/key_filter.sv
// rtl/key_filter.sv - push-button synchroniser, debouncer and press/release/long-press event generator
module key_filter #(
    parameter bit KEY_ACTIVE_LOW = 1'b1,
    parameter int CNT_W          = 20,
    parameter int CNT_MAX        = 999_999,
    parameter int LONG_W         = 25,
    parameter int LONG_MAX       = 24_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_in,
    output logic       key_state,
    output logic       key_flag,
    output logic       key_rel_flag,
    output logic       long_flag,
    output logic [7:0] press_cnt
);

    localparam logic              REL_LVL   = KEY_ACTIVE_LOW;
    localparam logic [CNT_W-1:0]  CNT_LIM   = CNT_W'(CNT_MAX);
    localparam logic [LONG_W-1:0] HOLD_LIM  = LONG_W'(LONG_MAX);
    localparam logic [LONG_W-1:0] HOLD_DONE = LONG_W'(LONG_MAX + 1);

    typedef enum logic [1:0] {IDLE, P_FILT, DOWN, R_FILT} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [LONG_W-1:0] hold, hold_nx;
    logic              key_state_nx, key_flag_nx, key_rel_flag_nx, long_flag_nx;
    logic [7:0]        press_cnt_nx;
    logic              s1, s2;
    logic              pressed;

    // Synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1 <= REL_LVL;
            s2 <= REL_LVL;
        end else begin
            s1 <= key_in;
            s2 <= s1;
        end
    end

    assign pressed = KEY_ACTIVE_LOW ? ~s2 : s2;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            hold         <= '0;
            key_state    <= 1'b0;
            key_flag     <= 1'b0;
            key_rel_flag <= 1'b0;
            long_flag    <= 1'b0;
            press_cnt    <= '0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            hold         <= hold_nx;
            key_state    <= key_state_nx;
            key_flag     <= key_flag_nx;
            key_rel_flag <= key_rel_flag_nx;
            long_flag    <= long_flag_nx;
            press_cnt    <= press_cnt_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        hold_nx         = hold;
        key_state_nx    = key_state;
        key_flag_nx     = 1'b0;
        key_rel_flag_nx = 1'b0;
        long_flag_nx    = 1'b0;
        press_cnt_nx    = press_cnt;
        case (state)
            IDLE: begin
                if (pressed) begin
                    state_nx = P_FILT;
                    cnt_nx   = '0;
                end
            end
            P_FILT: begin
                if (!pressed) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LIM) begin
                    state_nx     = DOWN;
                    key_flag_nx  = 1'b1;
                    key_state_nx = 1'b1;
                    press_cnt_nx = press_cnt + 8'd1;
                    hold_nx      = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DOWN: begin
                // hold parks at LONG_MAX+1 after firing, so long_flag fires once per press.
                if (!pressed) begin
                    state_nx = R_FILT;
                    cnt_nx   = '0;
                end else if (hold < HOLD_LIM) begin
                    hold_nx = hold + LONG_W'(1);
                end else if (hold == HOLD_LIM) begin
                    long_flag_nx = 1'b1;
                    hold_nx      = HOLD_DONE;
                end
            end
            R_FILT: begin
                if (pressed) begin
                    state_nx = DOWN;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LIM) begin
                    state_nx        = IDLE;
                    key_rel_flag_nx = 1'b1;
                    key_state_nx    = 1'b0;
                    hold_nx         = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_key_filter.sv
// tb/tb_key_filter.sv - directed segment table plus latency, long-press, reset and wrap sequences for key_filter
module tb_key_filter;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_in    = 1'b1;
    logic       key_state, key_flag, key_rel_flag, long_flag;
    logic [7:0] press_cnt;

    always #5 sys_clk = ~sys_clk;

    key_filter #(
        .KEY_ACTIVE_LOW(1'b1),
        .CNT_W(20),
        .CNT_MAX(9),
        .LONG_W(25),
        .LONG_MAX(49)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_in(key_in),
        .key_state(key_state),
        .key_flag(key_flag),
        .key_rel_flag(key_rel_flag),
        .long_flag(long_flag),
        .press_cnt(press_cnt)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_kf = 0, n_rel = 0, n_long = 0;
    int kf_cyc = -1, rel_cyc = -1, long_cyc = -1;
    int n_overlap = 0, n_wide = 0;
    logic p_kf = 1'b0, p_rel = 1'b0, p_long = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Event monitor: counts pulses, stamps their cycle, tracks overlap and stretched pulses.
    always @(negedge sys_clk) begin
        if (key_flag) begin n_kf++; kf_cyc = cyc; end
        if (key_rel_flag) begin n_rel++; rel_cyc = cyc; end
        if (long_flag) begin n_long++; long_cyc = cyc; end
        if ((int'(key_flag) + int'(key_rel_flag) + int'(long_flag)) > 1) n_overlap++;
        if ((key_flag && p_kf) || (key_rel_flag && p_rel) || (long_flag && p_long)) n_wide++;
        p_kf   = key_flag;
        p_rel  = key_rel_flag;
        p_long = long_flag;
    end

    typedef struct {
        logic key;
        int   cycles;
        int   kf;
        int   rel;
        int   lng;
        logic state;
        int   pcnt;
    } seg_t;

    seg_t segs[11];

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        step(2);
        sys_rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        int t, k0, r0, l0;

        segs[0]  = '{1'b1, 20, 0, 0, 0, 1'b0, 0};
        segs[1]  = '{1'b0,  9, 0, 0, 0, 1'b0, 0};
        segs[2]  = '{1'b1, 15, 0, 0, 0, 1'b0, 0};
        segs[3]  = '{1'b0, 11, 0, 0, 0, 1'b0, 0};
        segs[4]  = '{1'b1, 20, 1, 1, 0, 1'b0, 1};
        segs[5]  = '{1'b0, 30, 1, 0, 0, 1'b1, 2};
        segs[6]  = '{1'b1,  3, 0, 0, 0, 1'b1, 2};
        segs[7]  = '{1'b0,  5, 0, 0, 0, 1'b1, 2};
        segs[8]  = '{1'b1, 20, 0, 1, 0, 1'b0, 2};
        segs[9]  = '{1'b0, 80, 1, 0, 1, 1'b1, 3};
        segs[10] = '{1'b1, 20, 0, 1, 0, 1'b0, 3};

        sys_rst_n = 1'b0;
        key_in    = 1'b1;
        step(3);
        check("rst_key_state", key_state, 0);
        check("rst_key_flag", key_flag, 0);
        check("rst_rel_flag", key_rel_flag, 0);
        check("rst_long_flag", long_flag, 0);
        check("rst_press_cnt", press_cnt, 0);
        sys_rst_n = 1'b1;
        step(5);

        // Clean press, held into a long press, then clean release.
        k0 = n_kf; l0 = n_long;
        t = cyc;
        key_in = 1'b0;
        step(20);
        check("clean_latency", kf_cyc - t, 13);
        check("clean_kf_count", n_kf - k0, 1);
        check("clean_key_state", key_state, 1);
        check("clean_press_cnt", press_cnt, 1);
        step(93);
        check("long_count", n_long - l0, 1);
        check("long_latency", long_cyc - kf_cyc, 50);
        r0 = n_rel;
        t = cyc;
        key_in = 1'b1;
        step(20);
        check("rel_latency", rel_cyc - t, 13);
        check("rel_count", n_rel - r0, 1);
        check("rel_key_state", key_state, 0);

        // Press bounce: low 5, high 3, then held low.
        k0 = n_kf;
        key_in = 1'b0;
        step(5);
        key_in = 1'b1;
        step(3);
        t = cyc;
        key_in = 1'b0;
        step(20);
        check("bounce_kf_count", n_kf - k0, 1);
        check("bounce_latency", kf_cyc - t, 13);
        check("bounce_press_cnt", press_cnt, 2);

        // Reset while DOWN with the key still held.
        k0 = n_kf; r0 = n_rel; l0 = n_long;
        sys_rst_n = 1'b0;
        #1;
        check("midrst_key_state", key_state, 0);
        check("midrst_press_cnt", press_cnt, 0);
        step(3);
        check("midrst_no_flags", (n_kf - k0) + (n_rel - r0) + (n_long - l0), 0);
        t = cyc;
        sys_rst_n = 1'b1;
        step(20);
        check("midrst_latency", kf_cyc - t, 13);
        check("midrst_kf_count", n_kf - k0, 1);
        check("midrst_press_cnt_after", press_cnt, 1);
        key_in = 1'b1;
        step(20);

        do_reset();
        for (int i = 0; i < 11; i++) begin
            k0 = n_kf; r0 = n_rel; l0 = n_long;
            key_in = segs[i].key;
            step(segs[i].cycles);
            check($sformatf("seg%0d_kf", i), n_kf - k0, segs[i].kf);
            check($sformatf("seg%0d_rel", i), n_rel - r0, segs[i].rel);
            check($sformatf("seg%0d_long", i), n_long - l0, segs[i].lng);
            check($sformatf("seg%0d_state", i), key_state, segs[i].state);
            check($sformatf("seg%0d_pcnt", i), press_cnt, segs[i].pcnt);
        end

        do_reset();
        k0 = n_kf; r0 = n_rel;
        for (int i = 0; i < 255; i++) begin
            key_in = 1'b0;
            step(15);
            key_in = 1'b1;
            step(15);
        end
        check("wrap_cnt_255", press_cnt, 255);
        key_in = 1'b0;
        step(15);
        key_in = 1'b1;
        step(15);
        check("wrap_cnt_0", press_cnt, 0);
        check("wrap_kf_count", n_kf - k0, 256);
        check("wrap_rel_count", n_rel - r0, 256);

        check("flags_exclusive", n_overlap, 0);
        check("flags_one_cycle", n_wide, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
